// File: rtl/rv64g_l1_vlsu_miss_sched.sv
// VLSU miss scheduler: merges missed lanes per 64B line, issues one refill per line, then pulses replay.
// Optional VLSU_MISS_STATS_EN builds saturating refill/merge counters; otherwise the stat ports read zero.
module rv64g_l1_vlsu_miss_sched #(
  parameter int NUM_LANES = 8,
  parameter int ADDR_W    = 64,
  parameter int LINE_OFF  = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [NUM_LANES-1:0]        miss_mask_i,
  input  logic [NUM_LANES*ADDR_W-1:0] lane_addr_i,
  output logic                        busy_o,
  output logic                        refill_req_o,
  output logic [ADDR_W-1:0]           refill_addr_o,
  input  logic                        refill_ack_i,
  input  logic                        refill_done_i,
  output logic [NUM_LANES-1:0]        pending_o,
  output logic                        replay_o,
  output logic [15:0]                 stat_refills_o,
  output logic [15:0]                 stat_merged_o
);

  localparam int TAG_W = ADDR_W - LINE_OFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                     state_r;
  logic [NUM_LANES-1:0]       pending_r;
  logic [NUM_LANES*TAG_W-1:0] tag_r;
  logic [TAG_W-1:0]           line_r;
  logic                       busy_r;
  logic                       req_r;
  logic                       replay_r;

  logic [NUM_LANES*TAG_W-1:0] in_tag_s;
  logic                       unused_offset_s;
  logic [TAG_W-1:0]           sel_line_s;
  logic [TAG_W-1:0]           cmp_line_s;
  logic [NUM_LANES-1:0]       match_s;
  logic [NUM_LANES-1:0]       next_pending_s;
  logic                       done_take_s;

  // Only the line tag of each lane address matters; the byte offset is dropped on capture.
  always_comb begin
    in_tag_s        = '0;
    unused_offset_s = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      in_tag_s[k*TAG_W +: TAG_W] = lane_addr_i[k*ADDR_W+LINE_OFF +: TAG_W];
      unused_offset_s            = unused_offset_s ^ (^lane_addr_i[k*ADDR_W +: LINE_OFF]);
    end
  end

  // Lowest pending lane wins: scan high to low so the last hit is the lowest index.
  always_comb begin
    sel_line_s = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      sel_line_s = pending_r[k] ? tag_r[k*TAG_W +: TAG_W] : sel_line_s;
    end
  end

  // In the ack cycle the line is not captured yet, so compare against the live selection.
  always_comb begin
    cmp_line_s = (state_r == REQ) ? sel_line_s : line_r;
    match_s    = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      match_s[k] = (tag_r[k*TAG_W +: TAG_W] == cmp_line_s);
    end
    next_pending_s = pending_r & ~match_s;
    done_take_s    = refill_done_i &
                     ((state_r == WAIT) | ((state_r == REQ) & refill_ack_i));
  end

  // Scheduler FSM with registered control outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      pending_r <= '0;
      tag_r     <= '0;
      line_r    <= '0;
      busy_r    <= 1'b0;
      req_r     <= 1'b0;
      replay_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          replay_r <= 1'b0;
          if (start_i) begin
            pending_r <= miss_mask_i;
            tag_r     <= in_tag_s;
            busy_r    <= 1'b1;
            if (miss_mask_i != '0) begin
              state_r <= REQ;
              req_r   <= 1'b1;
            end else begin
              state_r  <= DONE;
              replay_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
            req_r  <= 1'b0;
          end
        end
        REQ: begin
          if (refill_ack_i) begin
            line_r <= sel_line_s;
            if (done_take_s) begin
              pending_r <= next_pending_s;
              if (next_pending_s != '0) begin
                state_r <= REQ;
              end else begin
                state_r  <= DONE;
                req_r    <= 1'b0;
                replay_r <= 1'b1;
              end
            end else begin
              state_r <= WAIT;
              req_r   <= 1'b0;
            end
          end else begin
            req_r <= 1'b1;
          end
        end
        WAIT: begin
          if (done_take_s) begin
            pending_r <= next_pending_s;
            if (next_pending_s != '0) begin
              state_r <= REQ;
              req_r   <= 1'b1;
            end else begin
              state_r  <= DONE;
              replay_r <= 1'b1;
            end
          end else begin
            req_r <= 1'b0;
          end
        end
        DONE: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          req_r    <= 1'b0;
          replay_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          req_r    <= 1'b0;
          replay_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_r;
  assign refill_req_o  = req_r;
  assign replay_o      = replay_r;
  assign pending_o     = pending_r;
  assign refill_addr_o = {sel_line_s, {LINE_OFF{1'b0}}};

`ifdef VLSU_MISS_STATS_EN
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      cnt = cnt + CNT_W'(v[k]);
    end
    return cnt;
  endfunction

  logic [15:0]      stat_refills_r;
  logic [15:0]      stat_merged_r;
  logic [CNT_W-1:0] cleared_cnt_s;
  logic [16:0]      refills_sum_s;
  logic [16:0]      merged_sum_s;

  assign cleared_cnt_s = popcount(pending_r & match_s);
  assign refills_sum_s = {1'b0, stat_refills_r} + 17'd1;
  assign merged_sum_s  = {1'b0, stat_merged_r} + 17'(cleared_cnt_s - CNT_W'(1));

  // Saturating counters; a done always clears at least the selected lane.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_refills_r <= 16'h0000;
      stat_merged_r  <= 16'h0000;
    end else begin
      if ((state_r == REQ) && refill_ack_i) begin
        stat_refills_r <= refills_sum_s[16] ? 16'hFFFF : refills_sum_s[15:0];
      end else begin
        stat_refills_r <= stat_refills_r;
      end
      if (done_take_s) begin
        stat_merged_r <= merged_sum_s[16] ? 16'hFFFF : merged_sum_s[15:0];
      end else begin
        stat_merged_r <= stat_merged_r;
      end
    end
  end

  assign stat_refills_o = stat_refills_r;
  assign stat_merged_o  = stat_merged_r;
`else
  assign stat_refills_o = 16'h0000;
  assign stat_merged_o  = 16'h0000;
`endif

endmodule

// File: tb/tb_rv64g_l1_vlsu_miss_sched.sv
// Self-checking bench for rv64g_l1_vlsu_miss_sched: directed scenarios plus randomized sequences
// checked against a line-list reference model.
module tb_rv64g_l1_vlsu_miss_sched;
  localparam int NL = 8;
  localparam int AW = 64;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [NL-1:0]  miss_mask_i;
  logic [NL*AW-1:0] lane_addr_i;
  logic           busy_o;
  logic           refill_req_o;
  logic [AW-1:0]  refill_addr_o;
  logic           refill_ack_i;
  logic           refill_done_i;
  logic [NL-1:0]  pending_o;
  logic           replay_o;
  logic [15:0]    stat_refills_o;
  logic [15:0]    stat_merged_o;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int exp_refills = 0;
  int exp_merged  = 0;
  logic [63:0] addrs [NL];

  rv64g_l1_vlsu_miss_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .miss_mask_i(miss_mask_i),
    .lane_addr_i(lane_addr_i), .busy_o(busy_o), .refill_req_o(refill_req_o),
    .refill_addr_o(refill_addr_o), .refill_ack_i(refill_ack_i), .refill_done_i(refill_done_i),
    .pending_o(pending_o), .replay_o(replay_o), .stat_refills_o(stat_refills_o),
    .stat_merged_o(stat_merged_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_stats(input string name);
`ifdef VLSU_MISS_STATS_EN
    chk_cnt++;
    if (stat_refills_o !== 16'(exp_refills)) $display("FAIL %s stat_refills: got %0d expected %0d", name, stat_refills_o, exp_refills);
    else pass_cnt++;
    chk_cnt++;
    if (stat_merged_o !== 16'(exp_merged)) $display("FAIL %s stat_merged: got %0d expected %0d", name, stat_merged_o, exp_merged);
    else pass_cnt++;
`else
    chk_cnt++;
    if ({stat_refills_o, stat_merged_o} !== 32'h0) $display("FAIL %s stats_tied: got %h expected 0", name, {stat_refills_o, stat_merged_o});
    else pass_cnt++;
`endif
  endtask

  // Runs one miss sequence; the expected line order and pending evolution come from the lane list.
  task automatic run_seq(input logic [7:0] mask, input int ack_dly, input int done_dly,
                         input bit stray, input string name);
    logic [63:0] lines [$];
    logic [63:0] ln;
    logic [7:0]  pend;
    bit          seen;
    int          w;
    int          cleared;
    for (int k = 0; k < NL; k++) begin
      if (mask[k]) begin
        ln = addrs[k] & ~64'h3F;
        seen = 1'b0;
        foreach (lines[q]) if (lines[q] == ln) seen = 1'b1;
        if (!seen) lines.push_back(ln);
      end
    end
    pend = mask;
    start_i = 1'b1;
    miss_mask_i = mask;
    for (int k = 0; k < NL; k++) lane_addr_i[k*AW +: AW] = addrs[k];
    @(negedge clk_i);
    start_i = 1'b0;
    miss_mask_i = 8'($urandom);
    chk_cnt++;
    if (busy_o !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, busy_o);
    else pass_cnt++;
    if (lines.size() == 0) begin
      chk_cnt++;
      if ({replay_o, refill_req_o} !== 2'b10) $display("FAIL %s zero_replay: got replay=%b req=%b expected 1/0", name, replay_o, refill_req_o);
      else pass_cnt++;
      @(negedge clk_i);
      chk_cnt++;
      if ({replay_o, busy_o} !== 2'b00) $display("FAIL %s zero_end: got replay=%b busy=%b expected 0/0", name, replay_o, busy_o);
      else pass_cnt++;
    end
    for (int i = 0; i < lines.size(); i++) begin
      w = 0;
      while (refill_req_o !== 1'b1 && w < 20) begin
        @(negedge clk_i);
        w++;
      end
      chk_cnt++;
      if (refill_req_o !== 1'b1) begin
        $display("FAIL %s req_timeout[%0d]: got req=%b expected 1", name, i, refill_req_o);
        return;
      end else pass_cnt++;
      chk_cnt++;
      if (refill_addr_o !== lines[i]) $display("FAIL %s addr[%0d]: got %h expected %h", name, i, refill_addr_o, lines[i]);
      else pass_cnt++;
      chk_cnt++;
      if (pending_o !== pend || replay_o !== 1'b0) $display("FAIL %s pend_req[%0d]: got %h/%b expected %h/0", name, i, pending_o, replay_o, pend);
      else pass_cnt++;
      for (int j = 0; j < ack_dly; j++) begin
        if (stray && i == 0 && j == 0) begin
          start_i = 1'b1;
          miss_mask_i = 8'h01;
          lane_addr_i = {NL{64'hDEAD_0000_0000_0000}};
        end
        @(negedge clk_i);
        start_i = 1'b0;
        chk_cnt++;
        if (refill_req_o !== 1'b1 || refill_addr_o !== lines[i] || pending_o !== pend)
          $display("FAIL %s stall[%0d.%0d]: got req=%b addr=%h pend=%h expected 1/%h/%h", name, i, j, refill_req_o, refill_addr_o, pending_o, lines[i], pend);
        else pass_cnt++;
      end
      refill_ack_i = 1'b1;
      refill_done_i = (done_dly == 0);
      @(negedge clk_i);
      refill_ack_i = 1'b0;
      refill_done_i = 1'b0;
      exp_refills++;
      if (done_dly > 0) begin
        for (int j = 1; j < done_dly; j++) begin
          chk_cnt++;
          if (refill_req_o !== 1'b0 || replay_o !== 1'b0) $display("FAIL %s wait[%0d]: got req=%b replay=%b expected 0/0", name, i, refill_req_o, replay_o);
          else pass_cnt++;
          @(negedge clk_i);
        end
        refill_done_i = 1'b1;
        @(negedge clk_i);
        refill_done_i = 1'b0;
      end
      cleared = 0;
      for (int k = 0; k < NL; k++) begin
        if (pend[k] && ((addrs[k] & ~64'h3F) == lines[i])) begin
          pend[k] = 1'b0;
          cleared++;
        end
      end
      exp_merged += cleared - 1;
      chk_cnt++;
      if (pending_o !== pend) $display("FAIL %s pend_done[%0d]: got %h expected %h", name, i, pending_o, pend);
      else pass_cnt++;
      if (i == lines.size() - 1) begin
        chk_cnt++;
        if ({replay_o, refill_req_o} !== 2'b10) $display("FAIL %s replay: got replay=%b req=%b expected 1/0", name, replay_o, refill_req_o);
        else pass_cnt++;
        @(negedge clk_i);
        chk_cnt++;
        if ({replay_o, busy_o} !== 2'b00) $display("FAIL %s end: got replay=%b busy=%b expected 0/0", name, replay_o, busy_o);
        else pass_cnt++;
      end else begin
        chk_cnt++;
        if (replay_o !== 1'b0) $display("FAIL %s early_replay[%0d]: got %b expected 0", name, i, replay_o);
        else pass_cnt++;
      end
    end
    check_stats(name);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_cnt++;
    if ({busy_o, refill_req_o, replay_o, pending_o, refill_addr_o} !== 75'h0)
      $display("FAIL reset: got busy=%b req=%b replay=%b pend=%h addr=%h expected all 0", busy_o, refill_req_o, replay_o, pending_o, refill_addr_o);
    else pass_cnt++;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_cnt++;
    if (busy_o !== 1'b0) $display("FAIL reset_idle: got busy=%b expected 0", busy_o);
    else pass_cnt++;
    exp_refills = 0;
    exp_merged = 0;
    check_stats("reset");
  endtask

  task automatic test_merge();
    addrs = '{64'h400, 64'h408, 64'h500, 64'h508, 64'h600, 64'h608, 64'h610, 64'h618};
    run_seq(8'hFF, 1, 3, 1'b0, "merge");
`ifdef VLSU_MISS_STATS_EN
    chk_cnt++;
    if ({stat_refills_o, stat_merged_o} !== {16'd3, 16'd5}) $display("FAIL merge_stats: got %0d/%0d expected 3/5", stat_refills_o, stat_merged_o);
    else pass_cnt++;
`endif
  endtask

  task automatic test_zero_mask();
    for (int k = 0; k < NL; k++) addrs[k] = {$urandom, $urandom};
    run_seq(8'h00, 0, 0, 1'b0, "zero_mask");
  endtask

  task automatic test_two_lines();
    for (int k = 0; k < NL; k++) addrs[k] = {$urandom, $urandom};
    addrs[0] = 64'h43C;
    addrs[7] = 64'h1007;
    run_seq(8'h81, 0, 2, 1'b0, "two_lines");
  endtask

  task automatic test_ack_stall();
    for (int k = 0; k < NL; k++) addrs[k] = {$urandom, $urandom};
    run_seq(8'h5A, 5, 1, 1'b1, "ack_stall");
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k < NL; k++) addrs[k] = 64'h2000 + 64'(k) * 64'h40;
    start_i = 1'b1;
    miss_mask_i = 8'hFF;
    for (int k = 0; k < NL; k++) lane_addr_i[k*AW +: AW] = addrs[k];
    @(negedge clk_i);
    start_i = 1'b0;
    refill_ack_i = 1'b1;
    @(negedge clk_i);
    refill_ack_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_cnt++;
    if ({busy_o, refill_req_o, pending_o} !== 10'h0) $display("FAIL reset_midop: got busy=%b req=%b pend=%h expected 0/0/00", busy_o, refill_req_o, pending_o);
    else pass_cnt++;
    refill_done_i = 1'b1;
    @(negedge clk_i);
    refill_done_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk_cnt++;
      if ({replay_o, busy_o, refill_req_o} !== 3'b000) $display("FAIL reset_midop_quiet[%0d]: got replay=%b busy=%b req=%b expected 0", j, replay_o, busy_o, refill_req_o);
      else pass_cnt++;
      @(negedge clk_i);
    end
    exp_refills = 0;
    exp_merged = 0;
    check_stats("reset_midop");
  endtask

  task automatic test_random();
    logic [63:0] pool [4];
    logic [7:0] mask;
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < 4; p++) pool[p] = {$urandom, $urandom} & ~64'h3F;
      for (int k = 0; k < NL; k++) addrs[k] = pool[$urandom_range(0, 3)] + 64'($urandom_range(0, 63));
      mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_seq(mask, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    miss_mask_i = '0;
    lane_addr_i = '0;
    refill_ack_i = 1'b0;
    refill_done_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_merge();
    test_zero_mask();
    test_two_lines();
    test_ack_stall();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/rv64g_l1_vlsu_miss_sched.md
Name: rv64g_l1_vlsu_miss_sched

Overview:
Sequences cache-line refills for a VLSU vector access that missed in the L1 dcache. It latches the per-lane miss mask and lane addresses, and merges lanes that fall in the same 64B line. It issues one refill request per distinct line to the dcache refill/TileLink path, waits for each line to be installed, then pulses replay so the dcache re-executes the vector access as all hits. It sits between the VLSU lane-hit logic and the dcache miss/refill engine.

Parameters:
NUM_LANES, 8, number of vector lanes
ADDR_W, 64, address width
LINE_OFF, 6, log2 of line size in bytes (64B lines)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle request to begin miss handling
miss_mask_i  in  NUM_LANES  lanes that missed (sampled with start_i)
lane_addr_i  in  NUM_LANES*ADDR_W  lane byte addresses, lane k at [(k+1)*ADDR_W-1 -: ADDR_W] (sampled with start_i)
busy_o  out  1  scheduler not in IDLE
refill_req_o  out  1  refill request valid
refill_addr_o  out  ADDR_W  line-aligned refill address
refill_ack_i  in  1  refill request accepted
refill_done_i  in  1  requested line installed in cache
pending_o  out  NUM_LANES  lanes still awaiting refill
replay_o  out  1  one-cycle pulse: all misses resolved, replay access

Behaviour:
- Reset (rst_i high at clk_i edge): state=IDLE; pending, latched addresses and current line are cleared; busy_o=0, refill_req_o=0, refill_addr_o=0, pending_o=0, replay_o=0. Reset mid-operation abandons the sequence; refill_req_o is low from the next edge and no replay_o is issued.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on start_i, latch miss_mask_i into pending and latch all lane addresses. If miss_mask_i is nonzero, go to REQ; otherwise go to DONE. start_i outside IDLE is ignored.
- Line selection (combinational from registers): lowest-index set pending bit selects a lane. refill_addr_o = that lane's address with bits [LINE_OFF-1:0] zeroed. Lines are therefore issued in lowest-pending-lane order.
- REQ: refill_req_o=1, and refill_addr_o holds stable until refill_ack_i. When ack is seen, capture the line and go to WAIT. If refill_done_i coincides with refill_ack_i, treat the cycle as ack plus done and follow the WAIT completion rule in the same cycle.
- WAIT: refill_req_o=0. On refill_done_i, clear pending bits for every latched lane whose address[ADDR_W-1:LINE_OFF] equals the current line. If the resulting pending is nonzero, go to REQ; otherwise go to DONE. refill_done_i outside WAIT (or the REQ ack cycle) is ignored.
- DONE: replay_o=1 for exactly one cycle, then go to IDLE.
- busy_o=1 in REQ, WAIT and DONE. pending_o reflects the pending register.
- Latency: start_i at cycle N gives refill_req_o at N+1. With an all-zero mask, replay_o is at N+1. The last refill_done_i at cycle M gives replay_o at M+1.
- Refill requests issued = number of distinct lines among the masked lanes (1..NUM_LANES); no line is requested twice.

Optional Feature:
VLSU_MISS_STATS_EN: adds outputs stat_refills_o [15:0] (refill requests accepted) and stat_merged_o [15:0] (lanes cleared beyond the first per refill). Both counters saturate at 16'hFFFF, clear on rst_i, and never otherwise. Without the macro these ports still exist but are tied to 0 and no counter logic is built.

Test Plan:
- Lanes 0x400,0x408,0x500,0x508,0x600,0x608,0x610,0x618, mask 8'hFF, ack/done returned 3 cycles apart -> exactly three requests, addresses 0x400, 0x500, 0x600 in that order; pending_o goes 8'hFC, 8'hF0, 8'h00; one replay_o pulse 1 cycle after the third done.
- start_i with mask 8'h00 -> no refill_req_o; replay_o high at N+1 only; busy_o high for 1 cycle.
- Mask 8'h81, lane0=0x43C, lane7=0x1007 -> requests 0x400 then 0x1000; replay after the second done.
- refill_ack_i held low 5 cycles -> refill_req_o and refill_addr_o stable throughout; a second start_i during this time is ignored.
- rst_i asserted in WAIT -> next edge: busy_o=0, pending_o=0, refill_req_o=0; no replay_o even if refill_done_i then arrives.
- With VLSU_MISS_STATS_EN, first scenario -> stat_refills_o=3, stat_merged_o=5.
